// File: rtl/line_buf_reader_if.sv
// Pixel stream from the line buffer reader to the display interface.
interface line_buf_reader_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sol;
  logic                  pix_eol;

  // Reader side: drives the pixel and its qualifiers, sees backpressure.
  modport master (
    output pix_data,
    output pix_valid,
    output pix_sol,
    output pix_eol,
    input  pix_ready
  );

  // Display side: consumes pixels, drives backpressure.
  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sol,
    input  pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/line_buf_reader.sv
// Read-side sequencer for the pixel line buffer ring: takes one credit per
// written line, issues buffer reads, converts the 1-cycle read latency into a
// valid/ready pixel stream through a 2-entry output FIFO, and hands each line
// slot back to the writer once its last pixel has been accepted.
module line_buf_reader #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LINE_PIXELS = 240,
  parameter int unsigned NUM_LINES   = 8
) (
  input  logic                  rclk_i,
  input  logic                  rst_i,
  input  logic                  line_ready_i,
  output logic                  read_en_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  line_buf_reader_if.master     pix_if,
  output logic                  line_done_o,
  output logic [3:0]            lines_avail_o,
  output logic                  overflow_o
);

  localparam int unsigned CNT_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Sequencer state
  logic [1:0]            state_q, state_d;
  logic [3:0]            lines_avail_q, lines_avail_d;
  logic                  overflow_q, overflow_d;
  logic [IDX_W-1:0]      line_idx_q, line_idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  line_done_q, line_done_d;

  // Read pipeline: data of a read issued last cycle is on rdata_i now
  logic                  rvalid_q, rvalid_d;
  logic                  rsol_q, rsol_d;
  logic                  reol_q, reol_d;

  // Output FIFO, entry 0 is the head and drives the pixel outputs
  logic [1:0]                 occ_q, occ_d;
  logic                       valid_q, valid_d;
  logic [1:0][DATA_WIDTH-1:0] ent_data_q, ent_data_d;
  logic [1:0]                 ent_sol_q, ent_sol_d;
  logic [1:0]                 ent_eol_q, ent_eol_d;

  logic pop_c;
  logic issue_ok_c;
  logic read_en_c;
  logic start_c;

  // Handshake and the FIFO space check, counting the read still in flight
  assign pop_c      = valid_q & pix_if.pix_ready;
  assign issue_ok_c = (3'(occ_q) + 3'(rvalid_q)) < (3'd2 + 3'(pop_c));

  // Next-state logic: FSM, address generation, ring position and credits
  always_comb begin
    state_d       = state_q;
    lines_avail_d = lines_avail_q;
    overflow_d    = overflow_q;
    line_idx_d    = line_idx_q;
    base_d        = base_q;
    pix_cnt_d     = pix_cnt_q;
    raddr_d       = raddr_q;
    line_done_d   = 1'b0;
    read_en_c     = 1'b0;
    start_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lines_avail_q != 4'd0) begin
          state_d   = ST_READ;
          start_c   = 1'b1;
          pix_cnt_d = '0;
          raddr_d   = base_q;
        end
      end
      ST_READ: begin
        if (issue_ok_c) begin
          read_en_c = 1'b1;
          if (pix_cnt_q == CNT_W'(LINE_PIXELS - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            raddr_d   = raddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop_c && ent_eol_q[0]) begin
          state_d     = ST_IDLE;
          line_done_d = 1'b1;
          if (line_idx_q == IDX_W'(NUM_LINES - 1)) begin
            line_idx_d = '0;
            base_d     = '0;
          end else begin
            line_idx_d = line_idx_q + IDX_W'(1);
            base_d     = base_q + ADDR_WIDTH'(LINE_PIXELS);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A credit arriving when the ring is already full is dropped and flagged
    case ({line_ready_i, start_c})
      2'b10: begin
        if (lines_avail_q == 4'(NUM_LINES)) begin
          overflow_d = 1'b1;
        end else begin
          lines_avail_d = lines_avail_q + 4'd1;
        end
      end
      2'b01: begin
        lines_avail_d = lines_avail_q - 4'd1;
      end
      default: begin
      end
    endcase
  end

  // Next-state logic: read pipeline flags and the 2-entry output FIFO
  always_comb begin
    rvalid_d   = read_en_c;
    rsol_d     = (pix_cnt_q == '0);
    reol_d     = (pix_cnt_q == CNT_W'(LINE_PIXELS - 1));
    occ_d      = occ_q;
    ent_data_d = ent_data_q;
    ent_sol_d  = ent_sol_q;
    ent_eol_d  = ent_eol_q;

    case (occ_q)
      2'd0: begin
        if (rvalid_q) begin
          ent_data_d[0] = rdata_i;
          ent_sol_d[0]  = rsol_q;
          ent_eol_d[0]  = reol_q;
          occ_d         = 2'd1;
        end
      end
      2'd1: begin
        if (rvalid_q && pop_c) begin
          ent_data_d[0] = rdata_i;
          ent_sol_d[0]  = rsol_q;
          ent_eol_d[0]  = reol_q;
        end else if (rvalid_q) begin
          ent_data_d[1] = rdata_i;
          ent_sol_d[1]  = rsol_q;
          ent_eol_d[1]  = reol_q;
          occ_d         = 2'd2;
        end else if (pop_c) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop_c) begin
          ent_data_d[0] = ent_data_q[1];
          ent_sol_d[0]  = ent_sol_q[1];
          ent_eol_d[0]  = ent_eol_q[1];
          if (rvalid_q) begin
            ent_data_d[1] = rdata_i;
            ent_sol_d[1]  = rsol_q;
            ent_eol_d[1]  = reol_q;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase

    valid_d = (occ_d != 2'd0);
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge rclk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      lines_avail_q <= 4'd0;
      overflow_q    <= 1'b0;
      line_idx_q    <= '0;
      base_q        <= '0;
      pix_cnt_q     <= '0;
      raddr_q       <= '0;
      line_done_q   <= 1'b0;
      rvalid_q      <= 1'b0;
      rsol_q        <= 1'b0;
      reol_q        <= 1'b0;
      occ_q         <= 2'd0;
      valid_q       <= 1'b0;
      ent_data_q    <= '0;
      ent_sol_q     <= 2'b00;
      ent_eol_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      lines_avail_q <= lines_avail_d;
      overflow_q    <= overflow_d;
      line_idx_q    <= line_idx_d;
      base_q        <= base_d;
      pix_cnt_q     <= pix_cnt_d;
      raddr_q       <= raddr_d;
      line_done_q   <= line_done_d;
      rvalid_q      <= rvalid_d;
      rsol_q        <= rsol_d;
      reol_q        <= reol_d;
      occ_q         <= occ_d;
      valid_q       <= valid_d;
      ent_data_q    <= ent_data_d;
      ent_sol_q     <= ent_sol_d;
      ent_eol_q     <= ent_eol_d;
    end
  end

  // The read strobe depends on this cycle's pop so that a full line streams
  // without bubbles through only two FIFO entries.
  assign read_en_o        = read_en_c;
  assign raddr_o          = raddr_q;
  assign line_done_o      = line_done_q;
  assign lines_avail_o    = lines_avail_q;
  assign overflow_o       = overflow_q;
  assign pix_if.pix_data  = ent_data_q[0];
  assign pix_if.pix_sol   = ent_sol_q[0];
  assign pix_if.pix_eol   = ent_eol_q[0];
  assign pix_if.pix_valid = valid_q;

endmodule

// File: tb/tb_line_buf_reader.sv
// Directed bench for line_buf_reader with a buffer model holding data=address.
module tb_line_buf_reader;

  logic        rclk = 1'b0;
  logic        rst;
  logic        line_ready;
  logic        read_en;
  logic [11:0] raddr;
  logic [15:0] rdata;
  logic        line_done;
  logic [3:0]  lines_avail;
  logic        overflow;

  line_buf_reader_if #(.DATA_WIDTH(16)) pif ();

  line_buf_reader dut (
    .rclk_i        (rclk),
    .rst_i         (rst),
    .line_ready_i  (line_ready),
    .read_en_o     (read_en),
    .raddr_o       (raddr),
    .rdata_i       (rdata),
    .pix_if        (pif),
    .line_done_o   (line_done),
    .lines_avail_o (lines_avail),
    .overflow_o    (overflow)
  );

  always #5 rclk = ~rclk;

  // Buffer model: 1-cycle read latency, contents equal to the address
  logic [15:0] mem [0:2559];
  always @(posedge rclk) if (read_en) rdata <= mem[raddr];

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // Observation queues filled by the monitor
  int          rd_q[$];
  int          rd_cyc_q[$];
  int          px_q[$];
  bit          sol_q[$];
  bit          eol_q[$];
  int          px_cyc_q[$];
  int          ld_cyc_q[$];
  int          ld_cnt = 0;
  int          rd_tot = 0;
  int          pop_tot = 0;
  int          os_viol = 0;
  int          stab_viol = 0;
  bit          stall_prev = 1'b0;
  logic [15:0] d_prev;
  logic        s_prev;
  logic        e_prev;

  always @(negedge rclk) begin
    if (read_en) begin
      rd_q.push_back(int'(raddr));
      rd_cyc_q.push_back(cyc);
      rd_tot++;
    end
    if (pif.pix_valid && pif.pix_ready) begin
      px_q.push_back(int'(pif.pix_data));
      sol_q.push_back(pif.pix_sol);
      eol_q.push_back(pif.pix_eol);
      px_cyc_q.push_back(cyc);
      pop_tot++;
    end
    if (rd_tot - pop_tot > 2) os_viol++;
    if (stall_prev && (!pif.pix_valid || pif.pix_data !== d_prev ||
                       pif.pix_sol !== s_prev || pif.pix_eol !== e_prev))
      stab_viol++;
    stall_prev = pif.pix_valid && !pif.pix_ready;
    d_prev     = pif.pix_data;
    s_prev     = pif.pix_sol;
    e_prev     = pif.pix_eol;
    if (line_done) begin
      ld_cnt++;
      ld_cyc_q.push_back(cyc);
    end
    if (rst) begin
      rd_tot     = 0;
      pop_tot    = 0;
      stall_prev = 1'b0;
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic pulse_line(output int n);
    line_ready = 1'b1;
    n = cyc;
    step(1);
    line_ready = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int t = 0;
    while (ld_cnt < target && t < budget) begin
      step(1);
      t++;
    end
    check_eq(tag, ld_cnt, target);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_read_en"}, read_en, 0);
    check_eq({pfx, "_raddr"}, raddr, 0);
    check_eq({pfx, "_pix_valid"}, pif.pix_valid, 0);
    check_eq({pfx, "_pix_sol"}, pif.pix_sol, 0);
    check_eq({pfx, "_pix_eol"}, pif.pix_eol, 0);
    check_eq({pfx, "_line_done"}, line_done, 0);
    check_eq({pfx, "_lines_avail"}, lines_avail, 0);
    check_eq({pfx, "_overflow"}, overflow, 0);
  endtask

  initial begin
    for (int i = 0; i < 2560; i++) mem[i] = 16'(i);
    rst = 1'b1;
    line_ready = 1'b0;
    pif.pix_ready = 1'b0;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rb, pb, lb, errs, t;

    step(2);
    rst = 1'b0;
    step(1);
    check_reset_outputs("rst");

    // Single line
    pif.pix_ready = 1'b1;
    rb = rd_q.size(); pb = px_q.size(); lb = ld_cnt;
    pulse_line(n);
    check_eq("one_avail_n1", lines_avail, 1);
    check_eq("one_rden_n1", read_en, 0);
    wait_done(lb + 1, 400, "one_done");
    step(3);
    check_eq("one_nreads", rd_q.size() - rb, 240);
    check_eq("one_npix", px_q.size() - pb, 240);
    check_eq("one_first_rd_cyc", rd_cyc_q[rb] - n, 2);
    check_eq("one_first_px_cyc", px_cyc_q[pb] - n, 4);
    errs = 0;
    for (int i = 0; i < 240; i++) begin
      if (rd_q[rb + i] != i) errs++;
      if (px_q[pb + i] != i) errs++;
      if (sol_q[pb + i] != (i == 0)) errs++;
      if (eol_q[pb + i] != (i == 239)) errs++;
    end
    check_eq("one_seq_errs", errs, 0);
    check_eq("one_ld_pulses", ld_cnt - lb, 1);
    check_eq("one_ld_after_eol", ld_cyc_q[lb] - px_cyc_q[pb + 239], 1);
    check_eq("one_avail_end", lines_avail, 0);

    // Ring wrap over 9 lines
    do_reset();
    rb = rd_q.size(); pb = px_q.size(); lb = ld_cnt;
    for (int l = 0; l < 9; l++) begin
      pulse_line(n);
      wait_done(lb + l + 1, 400, "wrap_done");
      step(5);
    end
    check_eq("wrap_l7_base", rd_q[rb + 7 * 240], 1680);
    check_eq("wrap_l7_last", rd_q[rb + 8 * 240 - 1], 1919);
    check_eq("wrap_l8_base", rd_q[rb + 8 * 240], 0);
    errs = 0;
    for (int i = 0; i < 9 * 240; i++)
      if (px_q[pb + i] != ((i / 240) % 8) * 240 + (i % 240)) errs++;
    check_eq("wrap_data_errs", errs, 0);

    // Backpressure, 30% ready over two lines
    do_reset();
    rb = rd_q.size(); pb = px_q.size(); lb = ld_cnt;
    pulse_line(n);
    pulse_line(n);
    t = 0;
    while (ld_cnt < lb + 2 && t < 6000) begin
      pif.pix_ready = ($urandom_range(0, 99) < 30);
      step(1);
      t++;
    end
    pif.pix_ready = 1'b1;
    check_eq("bp_done", ld_cnt - lb, 2);
    step(3);
    check_eq("bp_npix", px_q.size() - pb, 480);
    errs = 0;
    for (int i = 0; i < 480 && pb + i < px_q.size(); i++)
      if (px_q[pb + i] != i) errs++;
    check_eq("bp_order_errs", errs, 0);
    check_eq("bp_stable_viol", stab_viol, 0);
    check_eq("bp_overfill_viol", os_viol, 0);

    // Credit boundaries
    do_reset();
    pif.pix_ready = 1'b0;
    pulse_line(n);
    step(3);
    check_eq("cr_avail_active", lines_avail, 0);
    for (int i = 0; i < 8; i++) pulse_line(n);
    check_eq("cr_avail_8", lines_avail, 8);
    check_eq("cr_ovf_8", overflow, 0);
    pif.pix_ready = 1'b1;
    t = 0;
    while (!line_done && t < 1000) begin
      step(1);
      t++;
    end
    check_eq("cr_ld_seen", line_done, 1);
    pulse_line(n);
    check_eq("cr_coinc_avail", lines_avail, 8);
    check_eq("cr_coinc_ovf", overflow, 0);
    pulse_line(n);
    check_eq("cr_9th_avail", lines_avail, 8);
    check_eq("cr_9th_ovf", overflow, 1);
    step(5);
    check_eq("cr_ovf_sticky", overflow, 1);

    // Reset mid-line
    do_reset();
    pif.pix_ready = 1'b1;
    pulse_line(n);
    t = 0;
    while (raddr != 12'd100 && t < 400) begin
      step(1);
      t++;
    end
    check_eq("mid_reach", raddr, 100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("mid");
    step(3);
    check_eq("mid_no_stale_valid", pif.pix_valid, 0);
    check_eq("mid_avail_idle", lines_avail, 0);
    rb = rd_q.size(); pb = px_q.size(); lb = ld_cnt;
    pulse_line(n);
    wait_done(lb + 1, 400, "mid_done");
    step(2);
    check_eq("mid_restart_raddr", rd_q[rb], 0);
    check_eq("mid_restart_px", px_q[pb], 0);
    check_eq("mid_restart_npix", px_q.size() - pb, 240);

    // Full throughput, 3 back-to-back lines
    do_reset();
    pif.pix_ready = 1'b1;
    rb = rd_q.size(); pb = px_q.size(); lb = ld_cnt;
    pulse_line(n);
    pulse_line(n);
    pulse_line(n);
    wait_done(lb + 3, 1200, "tp_done");
    step(3);
    check_eq("tp_npix", px_q.size() - pb, 720);
    errs = 0;
    for (int i = 1; i < 720 && pb + i < px_cyc_q.size(); i++)
      if ((i % 240) != 0 && px_cyc_q[pb + i] != px_cyc_q[pb + i - 1] + 1) errs++;
    check_eq("tp_bubbles", errs, 0);
    check_eq("tp_gap_l1", px_cyc_q[pb + 240] - px_cyc_q[pb + 239], 4);
    check_eq("tp_gap_l2", px_cyc_q[pb + 480] - px_cyc_q[pb + 479], 4);
    check_eq("tp_rd_gap_l1", rd_cyc_q[rb + 240] - px_cyc_q[pb + 239], 2);
    check_eq("tp_overfill_viol", os_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
